// File: rtl/fp32_to_mxint_block_quantizer_pkg.sv
// Shared FP32 field layout, MXINT default widths and FSM state encodings
// for the FP32 -> MXINT block quantizer.
package fp32_to_mxint_block_quantizer_pkg;

    // FP32 field layout
    localparam int FP32_W     = 32;
    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP32_SIG_W = FP32_MAN_W + 1;
    localparam int FP32_BIAS  = 127;

    localparam logic [FP32_EXP_W-1:0] EXP_ALL_ONES = '1;
    localparam logic [FP32_EXP_W-1:0] EXP_ZERO     = '0;

    // Default MXINT geometry (MXINT8 with 32-element blocks)
    localparam int ELEM_WIDTH_DEF  = 8;
    localparam int BLOCK_SIZE_DEF  = 32;
    localparam int SCALE_WIDTH_DEF = FP32_EXP_W;

    typedef logic [ELEM_WIDTH_DEF-1:0]  elem_t;
    typedef logic [SCALE_WIDTH_DEF-1:0] scale_t;

    // FSM encodings, exposed on the debug state port
    typedef logic [1:0] state_t;
    localparam state_t ST_FILL  = 2'd0;
    localparam state_t ST_QUANT = 2'd1;
    localparam state_t ST_OUT   = 2'd2;

    // Biased exponent field of an FP32 word
    function automatic logic [FP32_EXP_W-1:0] fp32_exp(input logic [FP32_W-1:0] v);
        return v[FP32_W-2 -: FP32_EXP_W];
    endfunction

endpackage

// File: rtl/fp32_to_mxint_block_quantizer_elem_quant.sv
// Combinational quantizer for one FP32 value against the block's shared
// exponent: align, round (RNE or truncate), saturate, apply sign.
module fp32_mxint_elem_quant
    import fp32_to_mxint_block_quantizer_pkg::*;
#(
    parameter int ELEM_WIDTH = 8
) (
    input  logic [FP32_W-1:0]     i_value,
    input  logic [FP32_EXP_W-1:0] i_max_exp,
    input  logic                  i_round_mode,
    output logic [ELEM_WIDTH-1:0] o_element,
    output logic                  o_saturated,
    output logic                  o_is_zero
);

    // Magnitude bits kept (sign excluded)
    localparam int MW = ELEM_WIDTH - 1;
    // Significand followed by enough zero padding that every bit shifted
    // out below the guard position still lands in the sticky window.
    localparam int XW = FP32_SIG_W + FP32_SIG_W + ELEM_WIDTH;
    // Shift distance beyond which nothing of the significand survives
    localparam logic [FP32_EXP_W-1:0] D_FAR = FP32_EXP_W'(FP32_SIG_W + ELEM_WIDTH);
    localparam logic [MW-1:0] MAG_MAX = '1;

    logic                  w_sign;
    logic [FP32_EXP_W-1:0] w_exp;
    logic [FP32_SIG_W-1:0] w_sig;
    logic [FP32_EXP_W-1:0] w_d;
    logic [XW-1:0]         w_ext;
    logic [XW-1:0]         w_sh;
    logic [MW-1:0]         w_mag;
    logic                  w_guard;
    logic                  w_sticky;
    logic                  w_inc;
    logic [MW:0]           w_mag_rnd;
    logic                  w_flush;
    logic                  w_sat;
    logic [MW-1:0]         w_mag_fin;
    logic [MW:0]           w_mag_ext;

    // Align, round, saturate and sign-apply one element
    always_comb begin
        w_sign  = i_value[FP32_W-1];
        w_exp   = fp32_exp(i_value);
        w_sig   = {1'b1, i_value[FP32_MAN_W-1:0]};
        w_d     = i_max_exp - w_exp;
        w_ext   = {w_sig, {(XW-FP32_SIG_W){1'b0}}};
        w_sh    = w_ext >> w_d;

        if (w_d >= D_FAR) begin
            w_mag    = '0;
            w_guard  = 1'b0;
            w_sticky = 1'b1;
        end else begin
            w_mag    = w_sh[XW-1 -: MW];
            w_guard  = w_sh[XW-1-MW];
            w_sticky = |w_sh[XW-2-MW:0];
        end

        // RNE: round up above the halfway point, or at it when lsb is odd
        w_inc     = !i_round_mode && w_guard && (w_sticky || w_mag[0]);
        w_mag_rnd = {1'b0, w_mag} + {{MW{1'b0}}, w_inc};

        // Zero/subnormal flush to 0; NaN/Inf is handled at block level
        w_flush = (w_exp == EXP_ZERO) || (w_exp == EXP_ALL_ONES);

        // Only an all-ones magnitude rounding up can overflow
        w_sat     = !w_flush && w_mag_rnd[MW];
        w_mag_fin = w_flush ? '0 : (w_mag_rnd[MW] ? MAG_MAX : w_mag_rnd[MW-1:0]);

        // Magnitude is at most 2^MW-1, so the most negative code never appears
        w_mag_ext   = {1'b0, w_mag_fin};
        o_element   = w_sign ? (~w_mag_ext + 1'b1) : w_mag_ext;
        o_saturated = w_sat;
        o_is_zero   = (w_mag_fin == '0);
    end

endmodule

// File: rtl/fp32_to_mxint_block_quantizer.sv
// FP32 -> MXINT block quantizer. Collects a block of FP32 beats, tracks the
// shared (max) exponent, quantizes one slot per cycle, then presents the
// whole block on a valid/ready output.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. in_ready_o is high only in FILL; out_valid_o only in OUT, and
// the out_* bundle is held stable until the out handshake completes.
module fp32_to_mxint_block_quantizer
    import fp32_to_mxint_block_quantizer_pkg::*;
#(
    parameter int ELEM_WIDTH  = ELEM_WIDTH_DEF,
    parameter int BLOCK_SIZE  = BLOCK_SIZE_DEF,
    parameter int SCALE_WIDTH = SCALE_WIDTH_DEF
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [FP32_W-1:0]                in_data_i,
    input  logic                             in_last_i,
    input  logic                             round_mode_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [SCALE_WIDTH-1:0]           out_scale_o,
    output logic [BLOCK_SIZE*ELEM_WIDTH-1:0] out_elements_o,
    output logic                             out_nan_o,
    output logic [$clog2(BLOCK_SIZE):0]      out_sat_cnt_o,
    output logic [$clog2(BLOCK_SIZE):0]      out_zero_num_o,
    output state_t                           dbg_state_o
);

    localparam int IW = $clog2(BLOCK_SIZE);
    localparam int CW = IW + 1;
    localparam logic [IW-1:0] LAST_SLOT = IW'(BLOCK_SIZE - 1);

    state_t                         r_state;
    logic [IW-1:0]                  r_idx;
    logic [IW-1:0]                  r_q_idx;
    logic [FP32_W-1:0]              r_buf [BLOCK_SIZE];
    logic [FP32_EXP_W-1:0]          r_max_exp;
    logic                           r_nan;
    logic                           r_round;
    logic [BLOCK_SIZE*ELEM_WIDTH-1:0] r_elems;
    logic [CW-1:0]                  r_sat_cnt;
    logic [CW-1:0]                  r_zero_num;
    logic [SCALE_WIDTH-1:0]         r_scale;

    logic                  w_accept;
    logic                  w_close;
    logic                  w_out_done;
    logic [FP32_EXP_W-1:0] w_in_exp;
    logic [ELEM_WIDTH-1:0] w_q_elem;
    logic                  w_q_sat;
    logic                  w_q_zero;

    assign in_ready_o     = (r_state == ST_FILL);
    assign out_valid_o    = (r_state == ST_OUT);
    assign w_accept       = in_valid_i && in_ready_o;
    assign w_close        = w_accept && (in_last_i || (r_idx == LAST_SLOT));
    assign w_out_done     = out_valid_o && out_ready_i;
    assign w_in_exp       = fp32_exp(in_data_i);

    assign out_scale_o    = r_scale;
    assign out_elements_o = r_elems;
    assign out_nan_o      = r_nan && out_valid_o;
    assign out_sat_cnt_o  = r_sat_cnt;
    assign out_zero_num_o = r_zero_num;
    assign dbg_state_o    = r_state;

    fp32_mxint_elem_quant #(
        .ELEM_WIDTH (ELEM_WIDTH)
    ) u_elem_quant (
        .i_value      (r_buf[r_q_idx]),
        .i_max_exp    (r_max_exp),
        .i_round_mode (r_round),
        .o_element    (w_q_elem),
        .o_saturated  (w_q_sat),
        .o_is_zero    (w_q_zero)
    );

    // Element buffer: cleared between blocks so unfilled slots read as 0.0
    always_ff @(posedge clk_i) begin
        if (rst_i || w_out_done) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_accept) begin
            r_buf[r_idx] <= in_data_i;
        end
    end

    // FSM, exponent/NaN tracking, quantization accumulators and result regs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_FILL;
            r_idx      <= '0;
            r_q_idx    <= '0;
            r_max_exp  <= '0;
            r_nan      <= 1'b0;
            r_round    <= 1'b0;
            r_elems    <= '0;
            r_sat_cnt  <= '0;
            r_zero_num <= '0;
            r_scale    <= '0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        // Rounding mode is fixed for the block by its first beat
                        if (r_idx == '0) begin
                            r_round <= round_mode_i;
                        end
                        if (w_in_exp == EXP_ALL_ONES) begin
                            r_nan <= 1'b1;
                        end else if ((w_in_exp != EXP_ZERO) && (w_in_exp > r_max_exp)) begin
                            r_max_exp <= w_in_exp;
                        end
                        if (w_close) begin
                            r_state <= ST_QUANT;
                            r_idx   <= '0;
                            r_q_idx <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_QUANT: begin
                    // A NaN/Inf anywhere in the block zeroes every element
                    r_elems[r_q_idx*ELEM_WIDTH +: ELEM_WIDTH] <= r_nan ? '0 : w_q_elem;
                    r_sat_cnt  <= r_sat_cnt + CW'(w_q_sat && !r_nan);
                    r_zero_num <= r_zero_num + CW'(w_q_zero || r_nan);
                    r_q_idx    <= r_q_idx + 1'b1;
                    if (r_q_idx == LAST_SLOT) begin
                        r_state <= ST_OUT;
                        r_scale <= r_nan ? '1 : SCALE_WIDTH'(r_max_exp);
                    end
                end
                ST_OUT: begin
                    if (out_ready_i) begin
                        r_state    <= ST_FILL;
                        r_max_exp  <= '0;
                        r_nan      <= 1'b0;
                        r_elems    <= '0;
                        r_sat_cnt  <= '0;
                        r_zero_num <= '0;
                        r_scale    <= '0;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_to_mxint_block_quantizer.sv
// Directed bench for the FP32 -> MXINT block quantizer (default geometry:
// MXINT8, 32-element blocks).
module tb_fp32_to_mxint_block_quantizer;
    import fp32_to_mxint_block_quantizer_pkg::*;

    localparam int EW = 8;
    localparam int BS = 32;
    localparam int VW = EW * BS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_last;
    logic          round_mode;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_scale;
    logic [VW-1:0] out_elements;
    logic          out_nan;
    logic [5:0]    out_sat_cnt;
    logic [5:0]    out_zero_num;
    state_t        dbg_state;

    fp32_to_mxint_block_quantizer #(
        .ELEM_WIDTH  (EW),
        .BLOCK_SIZE  (BS),
        .SCALE_WIDTH (8)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .in_last_i      (in_last),
        .round_mode_i   (round_mode),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_scale_o    (out_scale),
        .out_elements_o (out_elements),
        .out_nan_o      (out_nan),
        .out_sat_cnt_o  (out_sat_cnt),
        .out_zero_num_o (out_zero_num),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] blk   [BS];
    elem_t       exp_e [BS];
    int          lat;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [VW-1:0] pack_exp();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < BS; i++) v[i*EW +: EW] = exp_e[i];
        return v;
    endfunction

    task automatic clear_tables();
        for (int i = 0; i < BS; i++) begin
            blk[i]   = 32'h0;
            exp_e[i] = '0;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Sends blk[0..n-1]; round_mode is flipped after the first beat so a
    // mid-block change would show up in the results if it leaked in.
    task automatic send_beats(input int n, input logic rm, input bit use_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_data    = blk[i];
            in_last    = use_last && (i == n - 1);
            round_mode = (i == 0) ? rm : ~rm;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'h0;
    endtask

    // Counts negedges from just after the closing beat until out_valid
    task automatic wait_out(input string tag);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, VW'(lat), VW'(BS));
    endtask

    task automatic check_result(input string tag, input logic [7:0] scale, input logic nan,
                                input int sat, input int zeros);
        chk({tag, "_valid"},    VW'(out_valid),    VW'(1));
        chk({tag, "_in_ready"}, VW'(in_ready),     VW'(0));
        chk({tag, "_state"},    VW'(dbg_state),    VW'(ST_OUT));
        chk({tag, "_scale"},    VW'(out_scale),    VW'(scale));
        chk({tag, "_nan"},      VW'(out_nan),      VW'(nan));
        chk({tag, "_sat"},      VW'(out_sat_cnt),  VW'(sat));
        chk({tag, "_zero"},     VW'(out_zero_num), VW'(zeros));
        chk({tag, "_elems"},    out_elements,      pack_exp());
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, VW'(out_valid),    VW'(0));
        chk({tag, "_post_ready"}, VW'(in_ready),     VW'(1));
        chk({tag, "_post_elems"}, out_elements,      VW'(0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 32'h0;
        in_last    = 1'b0;
        round_mode = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_in_ready",  VW'(in_ready),     VW'(1));
        chk("rst_out_valid", VW'(out_valid),    VW'(0));
        chk("rst_scale",     VW'(out_scale),    VW'(0));
        chk("rst_elems",     out_elements,      VW'(0));
        chk("rst_counts",    VW'({out_sat_cnt, out_zero_num, out_nan}), VW'(0));
        chk("rst_state",     VW'(dbg_state),    VW'(ST_FILL));
        rst = 1'b0;

        // 1: full block of 1.0 -> scale 127, every element 0x40
        clear_tables();
        for (int i = 0; i < BS; i++) begin
            blk[i]   = 32'h3F80_0000;
            exp_e[i] = 8'h40;
        end
        send_beats(BS, 1'b0, 1'b1);
        wait_out("s1");
        check_result("s1", 8'(FP32_BIAS), 1'b0, 0, 0);
        handshake("s1");

        // 2: short block 1.0, 0.5, -1.0 closed by in_last
        clear_tables();
        blk[0] = 32'h3F80_0000; exp_e[0] = 8'h40;
        blk[1] = 32'h3F00_0000; exp_e[1] = 8'h20;
        blk[2] = 32'hBF80_0000; exp_e[2] = 8'hC0;
        send_beats(3, 1'b0, 1'b1);
        wait_out("s2");
        check_result("s2", 8'd127, 1'b0, 0, 29);
        handshake("s2");

        // 3a: rounding cases under RNE
        //   0x3F830000: guard=1, lsb=1          -> up   0x42
        //   0x3F810001: guard=1, sticky=1       -> up   0x41
        //   0x2B800000: d=40, beyond 24+8       -> 0
        //   0x3F810000: guard=1, tie, lsb even  -> stay 0x40
        clear_tables();
        blk[0] = 32'h3F80_0000; exp_e[0] = 8'h40;
        blk[1] = 32'h3F83_0000; exp_e[1] = 8'h42;
        blk[2] = 32'h3F81_0001; exp_e[2] = 8'h41;
        blk[3] = 32'h2B80_0000; exp_e[3] = 8'h00;
        blk[4] = 32'h3F81_0000; exp_e[4] = 8'h40;
        send_beats(5, 1'b0, 1'b1);
        wait_out("s3_rne");
        check_result("s3_rne", 8'd127, 1'b0, 0, 28);
        handshake("s3_rne");

        // 3b: same values truncated
        exp_e[1] = 8'h41;
        exp_e[2] = 8'h40;
        send_beats(5, 1'b1, 1'b1);
        wait_out("s3_trunc");
        check_result("s3_trunc", 8'd127, 1'b0, 0, 28);
        handshake("s3_trunc");

        // 4: overflow on rounding -> saturate to +/-127
        clear_tables();
        blk[0] = 32'h3FFF_FFFF; exp_e[0] = 8'h7F;
        blk[1] = 32'hBFFF_FFFF; exp_e[1] = 8'h81;
        send_beats(2, 1'b0, 1'b1);
        wait_out("s4");
        check_result("s4", 8'd127, 1'b0, 2, 30);
        handshake("s4");

        // 5: NaN in slot 5 -> scale 0xFF, all elements zero
        clear_tables();
        for (int i = 0; i < BS; i++) blk[i] = 32'h3F80_0000;
        blk[5] = 32'h7FC0_0000;
        send_beats(BS, 1'b0, 1'b0);
        wait_out("s5");
        check_result("s5", 8'hFF, 1'b1, 0, 32);
        handshake("s5");

        // 6: drop a partial block with reset, then a clean full block
        clear_tables();
        for (int i = 0; i < BS; i++) blk[i] = 32'h3F80_0000;
        blk[0] = 32'h4000_0000;  // 2.0 in the dropped block would raise the scale
        send_beats(10, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("s6_rst_ready", VW'(in_ready),  VW'(1));
        chk("s6_rst_valid", VW'(out_valid), VW'(0));
        chk("s6_rst_state", VW'(dbg_state), VW'(ST_FILL));

        blk[0] = 32'h3F80_0000;
        for (int i = 0; i < BS; i++) exp_e[i] = 8'h40;
        send_beats(BS, 1'b0, 1'b0);
        wait_out("s6");
        check_result("s6", 8'd127, 1'b0, 0, 0);

        // Hold off the consumer; result must stay put and input stays closed
        in_valid = 1'b1;
        in_data  = 32'h4080_0000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("s6_hold_valid", VW'(out_valid), VW'(1));
            chk("s6_hold_ready", VW'(in_ready),  VW'(0));
            chk("s6_hold_scale", VW'(out_scale), VW'(127));
            chk("s6_hold_elems", out_elements,   pack_exp());
        end
        in_valid = 1'b0;
        in_data  = 32'h0;
        handshake("s6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
